// File: rtl/tdm_pkg.sv
// Shared types and helpers for the two-channel TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Level driven on sel_out while the line carries channel A.
  localparam logic SEL_A = 1'b1;

  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return parity_en ? 2 * (width + 1) : 2 * width;
  endfunction

endpackage

// File: rtl/tdm_deser.sv
// One channel of the demux: MSB-first shift register with running parity.
// The *_nxt outputs show the word/parity including the bit sampled on this edge.
module tdm_deser
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_din,
  input  logic             i_shift,
  input  logic             i_par,
  input  logic             i_clr,
  input  logic             i_seed,
  output logic [WIDTH-1:0] o_word_nxt,
  output logic             o_par_nxt
);

  logic [WIDTH-1:0] r_word;
  logic             r_par;

  always_comb begin
    o_word_nxt = i_shift ? {r_word[WIDTH-2:0], i_din} : r_word;
    o_par_nxt  = i_par ? (r_par ^ i_din) : r_par;
  end

  // A clear drops the running frame; a seed makes the current bit the first of a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_par  <= 1'b0;
    end else if (i_clr) begin
      r_word <= i_seed ? {{(WIDTH-1){1'b0}}, i_din} : '0;
      r_par  <= i_seed & i_din;
    end else begin
      r_word <= o_word_nxt;
      r_par  <= o_par_nxt;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Receive side of the 2:1 TDM link: slot counter, frame sync/flywheel and word outputs.
// Define DEMUX_PARITY_EN to expect an even-parity bit after each channel's LSB.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             frame_sync,
  output logic             sel_out,
  output logic [WIDTH-1:0] a_word,
  output logic [WIDTH-1:0] b_word,
  output logic             valid,
  output logic             locked,
  output logic             sync_err,
  output logic             par_err
);

`ifdef DEMUX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int unsigned    FL   = frame_len(WIDTH, PAR_EN);
  localparam int             SW   = $clog2(FL);
  localparam logic [SW-1:0]  LAST = SW'(FL - 1);
  localparam logic [SW-1:0]  ONE  = SW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_slot;
  logic [SW-1:0]   w_slot_nxt;

  logic            w_run;
  logic            w_resync;
  logic            w_start;
  logic            w_done;
  logic            w_is_a;
  logic            w_is_data;

  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_a_par_nxt;
  logic             w_b_par_nxt;

  logic             r_sel;
  logic [WIDTH-1:0] r_a_word;
  logic [WIDTH-1:0] r_b_word;
  logic             r_valid;
  logic             r_sync_err;

  // r_slot is the slot index of the bit sampled on the coming edge.
  always_comb begin
    w_run     = (r_state == RUN);
    w_resync  = w_run && frame_sync && (r_slot != '0);
    w_start   = frame_sync && (!w_run || (r_slot != '0));
    w_done    = w_run && (r_slot == LAST);
    w_is_a    = ~r_slot[0];
    w_is_data = int'(r_slot >> 1) < WIDTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    case (r_state)
      IDLE: begin
        if (frame_sync) begin
          w_state_nxt = RUN;
          w_slot_nxt  = ONE;
        end
      end
      RUN: begin
        if (w_resync) begin
          w_slot_nxt = ONE;
        end else if (w_done) begin
          w_slot_nxt = '0;
        end else begin
          w_slot_nxt = r_slot + ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_slot_nxt  = '0;
      end
    endcase
  end

  tdm_deser #(.WIDTH(WIDTH)) u_deser_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_din      (din),
    .i_shift    (w_run && w_is_a && w_is_data),
    .i_par      (w_run && w_is_a),
    .i_clr      (w_start || w_done),
    .i_seed     (w_start),
    .o_word_nxt (w_a_nxt),
    .o_par_nxt  (w_a_par_nxt)
  );

  // B never receives slot 0, so it is only ever cleared, never seeded.
  tdm_deser #(.WIDTH(WIDTH)) u_deser_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_din      (din),
    .i_shift    (w_run && !w_is_a && w_is_data),
    .i_par      (w_run && !w_is_a),
    .i_clr      (w_start || w_done),
    .i_seed     (1'b0),
    .o_word_nxt (w_b_nxt),
    .o_par_nxt  (w_b_par_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_a_word   <= '0;
      r_b_word   <= '0;
      r_valid    <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sel      <= ((w_state_nxt == RUN) && !w_slot_nxt[0]) ? SEL_A : ~SEL_A;
      r_valid    <= w_done;
      r_sync_err <= w_resync;
      if (w_done) begin
        r_a_word <= w_a_nxt;
        r_b_word <= w_b_nxt;
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_done && (w_a_par_nxt || w_b_par_nxt);
    end
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par;
  assign w_unused_par = w_a_par_nxt ^ w_b_par_nxt;
  assign par_err      = 1'b0;
`endif

  assign sel_out  = r_sel;
  assign a_word   = r_a_word;
  assign b_word   = r_b_word;
  assign valid    = r_valid;
  assign locked   = w_run;
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2: frame-level reference model plus directed literal checks.
module tb_tdm_demux2;

  localparam int W = 8;
`ifdef DEMUX_PARITY_EN
  localparam int FL = 2 * (W + 1);
  localparam bit PE = 1'b1;
`else
  localparam int FL = 2 * W;
  localparam bit PE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         frame_sync;
  logic         sel_out;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         valid;
  logic         locked;
  logic         sync_err;
  logic         par_err;

  int n_checks = 0;
  int n_errs   = 0;

  tdm_demux2 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .frame_sync (frame_sync),
    .sel_out    (sel_out),
    .a_word     (a_word),
    .b_word     (b_word),
    .valid      (valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: collects the bits of the current frame as a list and decodes it on completion.
  bit           m_run;
  int           m_k;
  bit           m_bits[$];
  logic [W-1:0] e_a, e_b;
  logic         e_valid, e_sync, e_lock, e_sel, e_perr;

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    m_bits.delete();
    e_a = '0; e_b = '0;
    e_valid = 0; e_sync = 0; e_lock = 0; e_sel = 0; e_perr = 0;
  endtask

  task automatic model_deliver();
    bit pa, pb;
    pa = 0; pb = 0;
    for (int i = 0; i < W; i++) begin
      e_a[W-1-i] = m_bits[2*i];
      e_b[W-1-i] = m_bits[2*i+1];
    end
    for (int i = 0; i < FL / 2; i++) begin
      pa ^= m_bits[2*i];
      pb ^= m_bits[2*i+1];
    end
    e_perr = PE && (pa || pb);
  endtask

  initial model_reset();

  always begin
    bit s_din, s_fs, s_rst;
    @(posedge clk);
    s_din = din; s_fs = frame_sync; s_rst = rst_n;
    e_valid = 0; e_sync = 0; e_perr = 0;
    if (!s_rst) begin
      model_reset();
    end else if (!m_run) begin
      if (s_fs) begin
        m_run = 1;
        m_bits.delete();
        m_bits.push_back(s_din);
        m_k = 1;
      end
    end else begin
      e_sync = s_fs && (m_k != 0);
      if (m_k == FL - 1) begin
        m_bits.push_back(s_din);
        model_deliver();
        e_valid = 1;
      end
      if (e_sync) begin
        m_bits.delete();
        m_bits.push_back(s_din);
        m_k = 1;
      end else if (m_k == FL - 1) begin
        m_bits.delete();
        m_k = 0;
      end else begin
        m_bits.push_back(s_din);
        m_k++;
      end
    end
    e_lock = m_run;
    e_sel  = m_run && (m_k % 2 == 0);
    @(negedge clk);
    if (!rst_n) model_reset();
    check("m_valid",    valid,    e_valid);
    check("m_sync_err", sync_err, e_sync);
    check("m_locked",   locked,   e_lock);
    check("m_sel_out",  sel_out,  e_sel);
    check("m_par_err",  par_err,  e_perr);
    check("m_a_word",   a_word,   e_a);
    check("m_b_word",   b_word,   e_b);
  end

  function automatic bit get_bit(input logic [W-1:0] a, input logic [W-1:0] b, input int s, input bit flip);
    int           p;
    logic [W-1:0] ch;
    p  = s / 2;
    ch = (s % 2 != 0) ? b : a;
    if (p < W) return ch[W-1-p];
    return (^ch) ^ (flip && (s % 2 == 0));
  endfunction

  // Presents one bit; returns just after the edge that sampled it.
  task automatic drive_bit(input bit d, input bit fs);
    din = d;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rest(input logic [W-1:0] a, input logic [W-1:0] b, input int from,
                           input bit fs0, input bit flip);
    for (int s = from; s < FL; s++) drive_bit(get_bit(a, b, s, flip), fs0 && (s == from));
  endtask

  task automatic expect_frame(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check({name, "_valid"}, valid, 1);
    check({name, "_a"}, a_word, a);
    check({name, "_b"}, b_word, b);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {sel_out, valid, locked, sync_err, par_err, a_word, b_word}, 0);
    rst_n = 1'b1;
    repeat (4) drive_bit(1'($urandom), 0);

    // Basic frame and flywheel sequence.
    send_rest(8'hA5, 8'h3C, 0, 1, 0);
    expect_frame("f_a5", 8'hA5, 8'h3C);
    check("f_a5_locked", locked, 1);
    send_rest(8'h01, 8'h80, 0, 1, 0);
    expect_frame("fw1", 8'h01, 8'h80);
    send_rest(8'hFF, 8'h00, 0, 0, 0);
    expect_frame("fw2", 8'hFF, 8'h00);
    send_rest(8'h5A, 8'hC3, 0, 0, 0);
    expect_frame("fw3", 8'h5A, 8'hC3);

    // Unexpected frame_sync at slot 5.
    for (int s = 0; s < 5; s++) drive_bit(get_bit(8'h11, 8'h22, s, 0), 0);
    drive_bit(get_bit(8'h6E, 8'h19, 0, 0), 1);
    @(negedge clk);
    check("resync_err", sync_err, 1);
    check("resync_novalid", valid, 0);
    check("resync_locked", locked, 1);
    send_rest(8'h6E, 8'h19, 1, 0, 0);
    expect_frame("resync", 8'h6E, 8'h19);

    // Reset while slot 9 is on the line.
    for (int s = 0; s < 9; s++) drive_bit(get_bit(8'h12, 8'h34, s, 0), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {sel_out, valid, locked, sync_err, par_err, a_word, b_word}, 0);
    repeat (2) drive_bit(1'($urandom), 0);
    rst_n = 1'b1;
    repeat (20) drive_bit(1'($urandom), 0);
    @(negedge clk);
    check("postrst_locked", locked, 0);
    check("postrst_valid", valid, 0);
    send_rest(8'hC7, 8'hE1, 0, 1, 0);
    expect_frame("postrst", 8'hC7, 8'hE1);

    // frame_sync on the completing slot: frame delivered and a new one starts.
    for (int s = 0; s < FL - 1; s++) drive_bit(get_bit(8'h33, 8'h81, s, 0), 0);
    drive_bit(get_bit(8'h33, 8'h81, FL - 1, 0), 1);
    expect_frame("coinc", 8'h33, 8'h81);
    check("coinc_sync", sync_err, 1);
    send_rest(8'h9C, 8'h42, 1, 0, 0);
`ifndef DEMUX_PARITY_EN
    expect_frame("coinc_next", 8'h9C, 8'h42);
`endif

`ifdef DEMUX_PARITY_EN
    send_rest(8'h07, 8'h00, 0, 1, 1);
    expect_frame("par_bad", 8'h07, 8'h00);
    check("par_bad_err", par_err, 1);
    send_rest(8'h07, 8'h00, 0, 0, 0);
    expect_frame("par_ok", 8'h07, 8'h00);
    check("par_ok_err", par_err, 0);
`endif

    // Random aligned frames, optional confirm syncs and parity faults.
    repeat (40) begin
      send_rest(W'($urandom), W'($urandom), 0, 1'($urandom), ($urandom_range(0, 5) == 0));
    end

    // Free-running random line with stray syncs and occasional resets.
    for (int c = 0; c < 2500; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      drive_bit(1'($urandom), ($urandom_range(0, 19) == 0));
    end
    rst_n = 1'b1;
    repeat (3) drive_bit(1'b0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
# tdm_demux2

Two-channel time-division demultiplexer: the receive end of the 2:1 transmission-gate mux link. It takes the single serial line driven by the mux, where slots alternate A, B, A, B, with select high meaning channel A. It regenerates the slot select, deserializes each channel MSB-first into a WIDTH-bit word, and presents both words together with a one-cycle valid strobe per frame. It sits directly behind the mux stage in the exp4 datapath, and a frame-sync pulse aligns it.

## Interface
- WIDTH, 8, bits per channel word (2..32)
- clk  in  1  sampling clock, one serial bit per rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  1  serial multiplexed data from the mux output
- frame_sync  in  1  high on the cycle din carries A[WIDTH-1] (first slot of a frame)
- sel_out  out  1  regenerated select: 1 during A slots, 0 during B slots
- a_word  out  WIDTH  last complete channel-A word
- b_word  out  WIDTH  last complete channel-B word
- valid  out  1  one-cycle strobe: a_word/b_word just updated
- locked  out  1  frame alignment acquired
- sync_err  out  1  one-cycle strobe: frame_sync seen at an unexpected slot
- par_err  out  1  one-cycle strobe with valid, parity mismatch (only with DEMUX_PARITY_EN)

## Operation
- Frame length FL = 2*WIDTH slots, or 2*(WIDTH+1) with parity. Slot s holds channel A when s is even and channel B when s is odd. Bit index = WIDTH-1 - s/2, MSB first.
- States:
  - IDLE: din is ignored. A frame_sync moves to RUN and samples the current din as slot 0.
  - RUN: the slot counter increments each cycle and wraps FL-1 -> 0.
- In RUN, frame_sync at slot 0 (expected) confirms lock, with no action.
- In RUN, frame_sync at any slot other than 0:
  - sync_err pulses.
  - The partial frame is discarded and no valid is issued.
  - The counter restarts with the current bit as slot 0.
  - locked stays 1.
- No frame_sync at slot 0 (flywheel): RUN continues, and the frame is still delivered.
- Frame completion: on the edge that samples slot FL-1, the shift registers are transferred to a_word/b_word. valid asserts the following cycle, for one cycle. Words hold until the next completion.
- locked = 1 in RUN, 0 in IDLE.
- sel_out = 1 in RUN on even slots. In IDLE sel_out = 0.
- Reset (asynchronous, any time, including mid-frame):
  - Go to IDLE and clear the counter and shift registers.
  - All outputs go to 0.
  - A partial frame is lost, and no valid follows.

## Timing
- Cycle 0 is the edge where frame_sync=1 is sampled in IDLE. Slots are sampled on cycles 0..FL-1.
- valid, a_word and b_word become visible after the edge of cycle FL-1, i.e. during cycle FL.
- Back-to-back frames give valid every FL cycles, with no gap slots.
- sel_out is registered and reflects the slot being sampled on the next edge. That way it can drive the upstream mux S directly with zero skew.
- sync_err is asserted during the cycle after the offending frame_sync edge.
- If frame_sync and a frame completion (slot FL-1) coincide:
  - The completing frame is still delivered (valid pulses).
  - sync_err also pulses.
  - The new frame starts at slot 0.

## Configuration
- DEMUX_PARITY_EN defined:
  - Each channel carries an extra even-parity bit after its LSB, so FL = 2*(WIDTH+1).
  - Parity bits are not stored in the words.
  - par_err = valid AND (parity(A)≠pA OR parity(B)≠pB). Words are delivered regardless.
- DEMUX_PARITY_EN undefined:
  - FL = 2*WIDTH.
  - par_err is tied to 0.

## Structure
- Package tdm_pkg holds:
  - state enum {IDLE, RUN}
  - function frame_len(width, parity_en)
  - constant SEL_A = 1'b1
- Sub-module tdm_deser, instantiated twice (A, B):
  - WIDTH-bit MSB-first shift register with enable, clear and parity accumulate.
  - The top level owns the counter, FSM and output registers.

## Test plan
- WIDTH=8, reset released, frame_sync at cycle 0, stream A=0xA5/B=0x3C interleaved -> valid in cycle 16, a_word=0xA5, b_word=0x3C, locked=1, sel_out pattern 1,0,1,0…
- Three consecutive frames (0x01/0x80, 0xFF/0x00, 0x5A/0xC3) with frame_sync only on the first -> three valids spaced 16 cycles apart, correct words each time (flywheel).
- Extra frame_sync at slot 5 of a frame -> sync_err one cycle, no valid for the partial frame, next valid 16 cycles after the resync with the new frame's words.
- rst_n low at slot 9 -> all outputs 0 immediately, state IDLE. din is ignored until the next frame_sync, and no spurious valid.
- DEMUX_PARITY_EN, A=0x07 sent with parity bit 0 -> valid at cycle 18, par_err=1, a_word=0x07. The correct parity frame gives par_err=0.
